// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment display monitor: cathode patterns,
// the blank pattern, the invalid-digit code and the monitor FSM encoding.
package seg7_pkg;

   // Active-low cathode patterns {a,b,c,d,e,f,g}, a = bit 6
   localparam logic [6:0] SEG_0     = 7'b0000001;
   localparam logic [6:0] SEG_1     = 7'b1001111;
   localparam logic [6:0] SEG_2     = 7'b0010010;
   localparam logic [6:0] SEG_3     = 7'b0000110;
   localparam logic [6:0] SEG_4     = 7'b1001100;
   localparam logic [6:0] SEG_5     = 7'b0100100;
   localparam logic [6:0] SEG_6     = 7'b0100000;
   localparam logic [6:0] SEG_7     = 7'b0001111;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0000100;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   localparam logic [3:0] DIGIT_INVALID = 4'hF;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_COLLECT = 2'd1;
   localparam logic [1:0] ST_DONE    = 2'd2;

endpackage

// File: rtl/seg7_pattern_to_bcd.sv
// Maps an active-low cathode pattern back to its BCD value; anything that is
// not one of the ten digit shapes reports DIGIT_INVALID and raises illegal.
module seg7_pattern_to_bcd
   import seg7_pkg::*;
(
   input  logic [6:0] pattern,
   output logic [3:0] value,
   output logic       illegal
);

   // Pattern lookup; default covers blanks and corrupted shapes
   always_comb begin
      value   = DIGIT_INVALID;
      illegal = 1'b0;
      case (pattern)
         SEG_0:   value = 4'd0;
         SEG_1:   value = 4'd1;
         SEG_2:   value = 4'd2;
         SEG_3:   value = 4'd3;
         SEG_4:   value = 4'd4;
         SEG_5:   value = 4'd5;
         SEG_6:   value = 4'd6;
         SEG_7:   value = 4'd7;
         SEG_8:   value = 4'd8;
         SEG_9:   value = 4'd9;
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/seven_segment_pattern_decoder.sv
// Display bus monitor: synchronises the multiplexed anode/cathode bus, waits
// for a stable sample, captures the shown digit and emits one frame strobe
// once every digit position has been seen.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   IDLE    | no digit captured for the current frame
//   COLLECT | some digits captured, waiting for the rest
//   DONE    | frame complete; publish shadow to outputs, clear mask
module seven_segment_pattern_decoder
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS    = 4,
   parameter int STABLE_CYCLES = 16,
   parameter int CNT_W         = 5
)
(
   input  logic                    clock_100Mhz,
   input  logic                    reset,
   input  logic [NUM_DIGITS-1:0]   anode_in,
   input  logic [6:0]              LED_in,
   output logic [4*NUM_DIGITS-1:0] digit_out,
   output logic [NUM_DIGITS-1:0]   pattern_error,
   output logic                    frame_valid
);

   localparam int SW = NUM_DIGITS + 7;
   localparam logic [SW-1:0] SYNC_IDLE = {{NUM_DIGITS{1'b1}}, SEG_BLANK};

   logic [SW-1:0]           sync1, sync2, s_prev;
   logic [CNT_W-1:0]        stab_cnt;
   logic [NUM_DIGITS-1:0]   an_sel;
   logic                    one_low, strobe, cap;
   logic [3:0]              dec_value;
   logic                    dec_illegal;
   logic [4*NUM_DIGITS-1:0] shadow;
   logic [NUM_DIGITS-1:0]   shadow_err, mask, mask_next;
   logic [1:0]              state, state_next;

   // Two-flop synchroniser plus the previous sample for the stability compare
   always_ff @(posedge clock_100Mhz or posedge reset) begin
      if (reset) begin
         sync1  <= SYNC_IDLE;
         sync2  <= SYNC_IDLE;
         s_prev <= SYNC_IDLE;
      end else begin
         sync1  <= {anode_in, LED_in};
         sync2  <= sync1;
         s_prev <= sync2;
      end
   end

   // Stability counter: clears on any change, saturates at STABLE_CYCLES-1
   always_ff @(posedge clock_100Mhz or posedge reset) begin
      if (reset) begin
         stab_cnt <= '0;
      end else if (sync2 != s_prev) begin
         stab_cnt <= '0;
      end else if (stab_cnt != CNT_W'(STABLE_CYCLES - 1)) begin
         stab_cnt <= stab_cnt + CNT_W'(1);
      end
   end

   // Active-high digit select; capture only when exactly one anode is low
   assign an_sel  = ~sync2[SW-1:7];
   assign one_low = (an_sel != '0) && ((an_sel & (an_sel - NUM_DIGITS'(1))) == '0);
   // Fires on the STABLE_CYCLES-th identical sample, once per stable period
   assign strobe  = (sync2 == s_prev) && (stab_cnt == CNT_W'(STABLE_CYCLES - 2));
   assign cap     = strobe && one_low;

   seg7_pattern_to_bcd u_dec (
      .pattern (sync2[6:0]),
      .value   (dec_value),
      .illegal (dec_illegal)
   );

   // Mask and next-state; DONE clears the mask before a coincident capture lands
   always_comb begin
      mask_next  = (state == ST_DONE) ? '0 : mask;
      state_next = (state == ST_DONE) ? ST_IDLE : state;
      if (cap) begin
         mask_next  = mask_next | an_sel;
         state_next = (mask_next == '1) ? ST_DONE : ST_COLLECT;
      end
   end

   // FSM and capture mask registers
   always_ff @(posedge clock_100Mhz or posedge reset) begin
      if (reset) begin
         state <= ST_IDLE;
         mask  <= '0;
      end else begin
         state <= state_next;
         mask  <= mask_next;
      end
   end

   // Shadow frame: a later capture of the same digit overwrites the entry
   always_ff @(posedge clock_100Mhz or posedge reset) begin
      if (reset) begin
         shadow     <= '0;
         shadow_err <= '0;
      end else if (cap) begin
         for (int k = 0; k < NUM_DIGITS; k++) begin
            if (an_sel[k]) begin
               shadow[4*k +: 4] <= dec_value;
               shadow_err[k]    <= dec_illegal;
            end
         end
      end
   end

   // Publish the completed frame; frame_valid coincides with the new outputs
   always_ff @(posedge clock_100Mhz or posedge reset) begin
      if (reset) begin
         digit_out     <= '0;
         pattern_error <= '0;
         frame_valid   <= 1'b0;
      end else begin
         frame_valid <= (state == ST_DONE);
         if (state == ST_DONE) begin
            digit_out     <= shadow;
            pattern_error <= shadow_err;
         end
      end
   end

endmodule
